// File: rtl/ask_tx_scheduler.sv
// ask_tx_scheduler
// Round-robin scheduler that shares one ASK transmitter between NREQ requesters.
// Flow: arbitrate in IDLE, strobe grant/tx_send in SEND, wait in WAIT for a rising
// edge of tx_sent, then hold off for GAP_CYCLES in GAP before the next arbitration.
//
// Parameters:
//   NREQ           number of requesters (2..8)
//   DATA_WIDTH     payload width
//   GAP_CYCLES     idle cycles between frame end and the next arbitration (0 allowed)
//   TIMEOUT_CYCLES WAIT-cycle limit, used only when ASK_SCHED_TIMEOUT_EN is defined
//
// Ports:
//   clk      system clock, posedge
//   reset    synchronous, active-low reset
//   req      level request per requester
//   req_data packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant    one-hot, one-cycle pulse marking the granted requester
//   done     one-hot, one-cycle pulse when the granted frame has completed
//   tx_data  payload to transmitter, captured at arbitration
//   tx_send  one-cycle send strobe to transmitter
//   tx_sent  completion level from transmitter
//   busy     high whenever the scheduler is not IDLE
//   timeout  one-cycle pulse on WAIT abort (tied 0 without ASK_SCHED_TIMEOUT_EN)
//
// Compile-time option: define ASK_SCHED_TIMEOUT_EN to enable the WAIT abort counter.

module ask_tx_scheduler #(
  parameter int NREQ           = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]      tx_data,
  output logic                       tx_send,
  input  logic                       tx_sent,
  output logic                       busy,
  output logic                       timeout
);

  localparam int PtrW = $clog2(NREQ);
  // Candidate index width: ptr + offset reaches at most 2*NREQ-1 before wrapping.
  localparam int CandW = PtrW + 1;
  localparam int GapW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

  state_e                r_state;
  logic [PtrW-1:0]       r_ptr;
  logic [NREQ-1:0]       r_grant;
  logic [NREQ-1:0]       r_done;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_send;
  logic                  r_busy;
  logic                  r_sent_prev;
  logic [GapW-1:0]       r_gap_cnt;

  logic                  w_found;
  logic [PtrW-1:0]       w_win;
  logic [CandW-1:0]      w_cand;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [NREQ-1:0]       w_ptr_oh;
  logic                  w_sent_rise;

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = {1'b0, r_ptr} + CandW'(i);
      if (w_cand >= CandW'(NREQ)) begin
        w_cand = w_cand - CandW'(NREQ);
      end
      if (!w_found && req[w_cand[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PtrW'(i)) begin
        w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_ptr_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ptr_oh[i] = (r_ptr == PtrW'(i));
    end
  end

  // Previous level is tracked in every state, so a level already high on WAIT
  // entry never looks like an edge.
  assign w_sent_rise = tx_sent & ~r_sent_prev;

`ifdef ASK_SCHED_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_ptr       <= PtrW'(NREQ - 1);
      r_grant     <= '0;
      r_done      <= '0;
      r_tx_data   <= '0;
      r_tx_send   <= 1'b0;
      r_busy      <= 1'b0;
      r_sent_prev <= 1'b0;
      r_gap_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_sent_prev <= tx_sent;
      r_grant     <= '0;
      r_done      <= '0;
      r_tx_send   <= 1'b0;
      r_timeout   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state   <= StSend;
            r_ptr     <= w_win;
            r_tx_data <= w_win_data;
            r_busy    <= 1'b1;
          end
        end
        StSend: begin
          r_grant   <= w_ptr_oh;
          r_tx_send <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= StWait;
        end
        StWait: begin
          if (w_sent_rise || (r_tmo_cnt == TmoLast)) begin
            // A completion edge wins over a simultaneous timeout.
            if (w_sent_rise) begin
              r_done <= w_ptr_oh;
            end else begin
              r_timeout <= 1'b1;
            end
            r_gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state <= StGap;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        StGap: begin
          if (r_gap_cnt >= GapLast) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign timeout = r_timeout;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_ptr       <= PtrW'(NREQ - 1);
      r_grant     <= '0;
      r_done      <= '0;
      r_tx_data   <= '0;
      r_tx_send   <= 1'b0;
      r_busy      <= 1'b0;
      r_sent_prev <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_sent_prev <= tx_sent;
      r_grant     <= '0;
      r_done      <= '0;
      r_tx_send   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state   <= StSend;
            r_ptr     <= w_win;
            r_tx_data <= w_win_data;
            r_busy    <= 1'b1;
          end
        end
        StSend: begin
          r_grant   <= w_ptr_oh;
          r_tx_send <= 1'b1;
          r_state   <= StWait;
        end
        StWait: begin
          // Without the abort counter the frame waits indefinitely.
          if (w_sent_rise) begin
            r_done    <= w_ptr_oh;
            r_gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state <= StGap;
            end
          end
        end
        StGap: begin
          if (r_gap_cnt >= GapLast) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign grant   = r_grant;
  assign done    = r_done;
  assign tx_data = r_tx_data;
  assign tx_send = r_tx_send;
  assign busy    = r_busy;

endmodule

// File: tb/tb_ask_tx_scheduler.sv
// Bench for ask_tx_scheduler: two instances (GAP_CYCLES=16 and GAP_CYCLES=0) share
// one stimulus stream; a cycle-indexed reference model predicts every output of both.
module tb_ask_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAPA = 16;
  localparam int TMO  = 32;
`ifdef ASK_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 tx_sent = 1'b0;

  logic [1:0][NREQ-1:0] g_grant;
  logic [1:0][NREQ-1:0] g_done;
  logic [1:0][DW-1:0]   g_data;
  logic [1:0]           g_send;
  logic [1:0]           g_busy;
  logic [1:0]           g_to;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  ask_tx_scheduler #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .GAP_CYCLES(GAPA), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(g_grant[0]), .done(g_done[0]), .tx_data(g_data[0]), .tx_send(g_send[0]),
    .tx_sent(tx_sent), .busy(g_busy[0]), .timeout(g_to[0])
  );

  ask_tx_scheduler #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)
  ) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(g_grant[1]), .done(g_done[1]), .tx_data(g_data[1]), .tx_send(g_send[1]),
    .tx_sent(tx_sent), .busy(g_busy[1]), .timeout(g_to[1])
  );

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, k, act, exp, ncyc);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Frames are tracked as edge timestamps: selection edge, completion edge, and the
  // first edge at which arbitration may happen again.
  bit                   m_infr[2];
  int                   m_ptr[2];
  int                   m_sel[2];
  int                   m_arb_at[2];
  int                   m_busy_until[2];
  logic [DW-1:0]        m_data[2];
  logic                 m_prev;
  logic [1:0][NREQ-1:0] e_grant, e_done;
  logic [1:0]           e_send, e_busy, e_to;

  initial begin
    int n, gk, w;
    logic s_rst, s_sent, hit;
    logic [NREQ-1:0] s_req;
    logic [NREQ*DW-1:0] s_data;
    n = 0;
    m_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_infr[k] = 0; m_ptr[k] = NREQ - 1; m_arb_at[k] = 0; m_busy_until[k] = -1;
      m_data[k] = '0;
    end
    forever begin
      @(posedge clk);
      n++;
      s_rst = reset; s_req = req; s_data = req_data; s_sent = tx_sent;
      hit = s_sent && !m_prev;
      for (int k = 0; k < 2; k++) begin
        gk = (k == 0) ? GAPA : 0;
        e_grant[k] = '0; e_done[k] = '0; e_send[k] = 1'b0; e_to[k] = 1'b0;
        if (!s_rst) begin
          m_infr[k] = 0; m_ptr[k] = NREQ - 1; m_arb_at[k] = n + 1;
          m_busy_until[k] = -1; m_data[k] = '0;
        end else if (m_infr[k]) begin
          if (n == m_sel[k] + 1) begin
            e_grant[k][m_ptr[k]] = 1'b1;
            e_send[k] = 1'b1;
          end else if (hit || (TO_EN && n == m_sel[k] + 1 + TMO)) begin
            if (hit) e_done[k][m_ptr[k]] = 1'b1;
            else e_to[k] = 1'b1;
            m_infr[k] = 0;
            m_arb_at[k] = n + gk + 1;
            m_busy_until[k] = n + gk - 1;
          end
        end else if (n >= m_arb_at[k] && s_req != '0) begin
          w = -1;
          for (int i = 1; i <= NREQ; i++) begin
            if (w < 0 && s_req[(m_ptr[k] + i) % NREQ]) w = (m_ptr[k] + i) % NREQ;
          end
          m_ptr[k] = w; m_infr[k] = 1; m_sel[k] = n;
          m_data[k] = s_data[w*DW +: DW];
        end
        e_busy[k] = m_infr[k] || (n <= m_busy_until[k]);
      end
      m_prev = s_rst ? s_sent : 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("grant", k, 32'(g_grant[k]), 32'(e_grant[k]));
        check("done", k, 32'(g_done[k]), 32'(e_done[k]));
        check("tx_send", k, 32'(g_send[k]), 32'(e_send[k]));
        check("tx_data", k, 32'(g_data[k]), 32'(m_data[k]));
        check("busy", k, 32'(g_busy[k]), 32'(e_busy[k]));
        check("timeout", k, 32'(g_to[k]), 32'(e_to[k]));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // sel: 0 grant, 1 done, 2 timeout. Returns one-hot index and observation cycle.
  task automatic wait_out(input int k, input int sel, input int limit,
                          output int idx, output int when);
    logic [NREQ-1:0] v;
    idx = -1; when = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      v = (sel == 0) ? g_grant[k] : (sel == 1) ? g_done[k] : NREQ'(g_to[k]);
      if (v != '0) begin
        for (int b = NREQ - 1; b >= 0; b--) if (v[b]) idx = b;
        when = ncyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait dut%0d sel%0d: no event within %0d cycles", k, sel, limit);
  endtask

  initial begin
    int idx, g, d, t, prev_d, cnt;
    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check("rst_grant", 0, 32'(g_grant[0]), 32'h0);
    check("rst_busy", 0, 32'(g_busy[0]), 32'h0);
    check("rst_tx_data", 0, 32'(g_data[0]), 32'h0);
    check("rst_tx_send", 0, 32'(g_send[0]), 32'h0);

    // Single frame: requester 0, payload A5
    reset = 1'b1; req = 4'b0001; req_data[7:0] = 8'hA5;
    wait_out(0, 0, 10, idx, g);
    check("first_grant", 0, 32'(g_grant[0]), 32'h1);
    check("first_send", 0, 32'(g_send[0]), 32'h1);
    check("first_data", 0, 32'(g_data[0]), 32'hA5);
    step(); req = '0; tx_sent = 1'b1;
    wait_out(0, 1, 4, idx, d);
    check("first_done", 0, 32'(g_done[0]), 32'h1);
    step(); tx_sent = 1'b0;

    // Round-robin with all requests held
    reset = 1'b0; step(); step(); reset = 1'b1; req = 4'b1111;
    prev_d = -1;
    for (int f = 0; f < 8; f++) begin
      wait_out(0, 0, 40, idx, g);
      check("rr_order", 0, 32'(idx), 32'(f % 4));
      if (f > 0) check("rr_spacing", 0, 32'(g - prev_d), 32'(2 + GAPA));
      step(); tx_sent = 1'b1;
      wait_out(0, 1, 4, idx, d);
      check("rr_done", 0, 32'(idx), 32'(f % 4));
      prev_d = d;
      step(); tx_sent = 1'b0;
    end

    // tx_sent already high before SEND: only a fresh rise counts
    req = 4'b0100; tx_sent = 1'b1;
    wait_out(0, 0, 40, idx, g);
    check("hi_grant", 0, 32'(idx), 32'd2);
    req = '0; cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (g_done[0] != '0) cnt++;
    end
    check("hi_no_done", 0, 32'(cnt), 32'd0);
    step(); tx_sent = 1'b0; step(); step(); tx_sent = 1'b1;
    wait_out(0, 1, 4, idx, d);
    check("hi_done", 0, 32'(idx), 32'd2);
    step(); tx_sent = 1'b0;

    // Reset in WAIT abandons the frame; requester 0 wins afterwards
    req = 4'b0010;
    wait_out(0, 0, 40, idx, g);
    check("rw_grant", 0, 32'(idx), 32'd1);
    step(); step(); step();
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rw_busy", 0, 32'(g_busy[0]), 32'h0);
    check("rw_done", 0, 32'(g_done[0]), 32'h0);
    check("rw_data", 0, 32'(g_data[0]), 32'h0);
    step(); reset = 1'b1; req = 4'b1111;
    wait_out(0, 0, 10, idx, g);
    check("rw_first", 0, 32'(idx), 32'd0);
    step(); tx_sent = 1'b1;
    wait_out(0, 1, 4, idx, d);
    step(); tx_sent = 1'b0;

    // GAP_CYCLES=0 instance: next grant two edges after done
    reset = 1'b0; step(); step(); reset = 1'b1; req = 4'b0011;
    wait_out(1, 0, 10, idx, g);
    check("g0_first", 1, 32'(idx), 32'd0);
    step(); tx_sent = 1'b1;
    wait_out(1, 1, 4, idx, d);
    step(); tx_sent = 1'b0;
    wait_out(1, 0, 10, idx, g);
    check("g0_second", 1, 32'(idx), 32'd1);
    check("g0_spacing", 1, 32'(g - d), 32'd2);
    step(); tx_sent = 1'b1;
    wait_out(1, 1, 4, idx, d);
    step(); tx_sent = 1'b0; req = '0;

`ifdef ASK_SCHED_TIMEOUT_EN
    // Stuck-low tx_sent: abort after TMO WAIT cycles, then requester 1
    reset = 1'b0; step(); step(); reset = 1'b1; req = 4'b0011;
    wait_out(0, 0, 10, idx, g);
    check("to_grant", 0, 32'(idx), 32'd0);
    wait_out(0, 2, TMO + 8, idx, t);
    check("to_latency", 0, 32'(t - g), 32'(TMO));
    wait_out(0, 0, 40, idx, g);
    check("to_next", 0, 32'(idx), 32'd1);
    check("to_spacing", 0, 32'(g - t), 32'(2 + GAPA));
    req = '0;
`endif

    // Randomised traffic against the model
    reset = 1'b0; step(); reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      req_data = (NREQ*DW)'($urandom);
      if ((c % 500) >= 440) tx_sent = 1'b0;
      else if ($urandom_range(0, 4) == 0) tx_sent = ~tx_sent;
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
